// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: FSM state encodings, default
// operand width and the decode control codes that drive start_i/signed_i.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  // ALU control codes decoded upstream; DIV selects signed_i=1, DIVU signed_i=0.
  localparam logic [5:0] DIV_CONTROL  = 6'h1a;
  localparam logic [5:0] DIVU_CONTROL = 6'h1b;

endpackage

// File: rtl/div_unit_if.sv
// Pipeline <-> divider handshake bundle. The pipeline (master) drives the
// request side, the divider (slave) returns ready_o and the result.
interface div_unit_if #(
  parameter int WIDTH = 32
) ();
  // Handshake: master raises start_i with stable operands and holds it until it
  // sees ready_o=1; the result is valid while ready_o=1 and start_i stays high.
  // Dropping start_i retires the result; annul_i aborts any operation at once.
  logic                 start_i;
  logic                 signed_i;
  logic [WIDTH-1:0]     opa_i;
  logic [WIDTH-1:0]     opb_i;
  logic                 annul_i;
  logic                 ready_o;
  logic [2*WIDTH-1:0]   result_o;

  modport master (
    output start_i, signed_i, opa_i, opb_i, annul_i,
    input  ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, opa_i, opb_i, annul_i,
    output ready_o, result_o
  );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude and keep the difference when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);
  logic [WIDTH:0] part;
  logic [WIDTH:0] trial;

  always_comb begin
    part   = {rem_i, msb_i};
    trial  = part - {1'b0, dsr_i};
    // part < 2*dsr always holds, so bit WIDTH of the difference is its sign.
    qbit_o = ~trial[WIDTH];
    rem_o  = qbit_o ? trial[WIDTH-1:0] : part[WIDTH-1:0];
  end
endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) producing {rem, quot}.
// Optional macro DIV_FASTPATH_EN: finish in one step when |opa| < |opb|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus,
  output div_state_e dbg_state_o
);
  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0]     dsr_q, dsr_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic                 ready_q, ready_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH-1:0]     step_rem;
  logic                 step_qbit;
  logic [WIDTH-1:0]     quo_next;

  assign a_neg = bus.signed_i & bus.opa_i[WIDTH-1];
  assign b_neg = bus.signed_i & bus.opb_i[WIDTH-1];
  assign mag_a = a_neg ? -bus.opa_i : bus.opa_i;
  assign mag_b = b_neg ? -bus.opb_i : bus.opb_i;

  // dvd_q doubles as the quotient: dividend bits shift out the top while
  // quotient bits shift in at the bottom.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .msb_i  (dvd_q[WIDTH-1]),
    .dsr_i  (dsr_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  assign quo_next = {dvd_q[WIDTH-2:0], step_qbit};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    ready_d  = ready_q;
    result_d = result_q;
    unique case (state_q)
      DIV_FREE: begin
        if (bus.start_i) begin
          dvd_d  = mag_a;
          dsr_d  = mag_b;
          rem_d  = '0;
          cnt_d  = '0;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          if (bus.opb_i == '0) begin
            state_d = DIV_BYZERO;
          end
`ifdef DIV_FASTPATH_EN
          else if (mag_a < mag_b) begin
            state_d  = DIV_END;
            ready_d  = 1'b1;
            result_d = {bus.opa_i, {WIDTH{1'b0}}};
          end
`endif
          else begin
            state_d = DIV_ON;
          end
        end
      end
      DIV_BYZERO: begin
        state_d  = DIV_END;
        ready_d  = 1'b1;
        result_d = '0;
      end
      DIV_ON: begin
        rem_d = step_rem;
        dvd_d = quo_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = DIV_END;
          ready_d  = 1'b1;
          result_d = {(negr_q ? -step_rem : step_rem),
                      (negq_q ? -quo_next : quo_next)};
        end
      end
      DIV_END: begin
        if (!bus.start_i) begin
          state_d  = DIV_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = DIV_FREE;
    endcase
    // Exception flush wins over everything, including a same-cycle start.
    if (bus.annul_i) begin
      state_d  = DIV_FREE;
      ready_d  = 1'b0;
      result_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.result_o = result_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit against an arithmetic reference model;
// honours DIV_FASTPATH_EN for the expected latency.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;
`ifdef DIV_FASTPATH_EN
  localparam int FAST_LAT = 2;
`else
  localparam int FAST_LAT = W + 2;
`endif

  logic       clk;
  logic       rst;
  div_state_e dbg_state;
  int         cyc;
  int         n_vec;
  int         n_miss;
  bit         chk_en;
  int         win_start;
  int         win_end;
  logic [2*W-1:0] exp_q[$];

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division; remainder follows the dividend's sign.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sgn, output logic [2*W-1:0] r,
                                output int lat);
    longint sa, sb, q, m;
    if (b == '0) begin
      r = '0;
      lat = 3;
      return;
    end
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    m = sa % sb;
    r = {m[W-1:0], q[W-1:0]};
    lat = W + 2;
`ifdef DIV_FASTPATH_EN
    if ((sa < 0 ? -sa : sa) < (sb < 0 ? -sb : sb)) lat = 2;
`endif
  endfunction

  // Compare process: ready_o/result_o checked every cycle against the window
  // in which the model says a result must be presented.
  always @(negedge clk) begin
    logic exp_rdy;
    if (chk_en) begin
      exp_rdy = (exp_q.size() > 0) && (cyc >= win_start) && (cyc < win_end);
      chk("ready_o", 64'(bus.ready_o), 64'(exp_rdy));
      chk("result_o", bus.result_o, exp_rdy ? exp_q[0] : 64'd0);
    end
  end

  // driver
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input int hold,
                         output logic [2*W-1:0] res, output int lat);
    logic [2*W-1:0] e;
    int l;
    int c0;
    bit got;
    model(a, b, sgn, e, l);
    @(posedge clk); #1;
    c0 = cyc;
    bus.start_i  = 1'b1;
    bus.signed_i = sgn;
    bus.opa_i    = a;
    bus.opb_i    = b;
    exp_q.push_back(e);
    win_start = c0 + l - 1;
    win_end   = 32'h7fffffff;
    got = 0;
    lat = 0;
    res = '0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) begin
        got = 1;
        lat = cyc - c0 + 1;
        res = bus.result_o;
      end else if (cyc > c0) begin
        bus.opa_i    = $urandom;
        bus.opb_i    = $urandom;
        bus.signed_i = 1'($urandom_range(0, 1));
      end
    end
    if (!got) chk("ready_timeout", 64'd0, 64'd1);
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    win_end = cyc + 1;
    @(posedge clk); #1;
    void'(exp_q.pop_front());
  endtask

  task automatic start_raw(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b0;
    bus.opa_i    = a;
    bus.opb_i    = b;
  endtask

  initial begin
    logic [2*W-1:0] res;
    logic [2*W-1:0] e;
    int lat;
    int l;
    n_vec = 0;
    n_miss = 0;
    chk_en = 0;
    win_start = 32'h7fffffff;
    win_end = 0;
    bus.start_i = 0;
    bus.signed_i = 0;
    bus.opa_i = '0;
    bus.opb_i = '0;
    bus.annul_i = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk_en = 1;
    @(negedge clk);
    chk("reset_state", 64'(dbg_state), 64'(DIV_FREE));
    chk("reset_ready", 64'(bus.ready_o), 64'd0);
    chk("reset_result", bus.result_o, 64'd0);

    // pin the model to hand-computed values
    model(32'd100, 32'd7, 1'b0, e, l);
    chk("model_100_7", e, 64'h00000002_0000000E);
    model(32'hFFFFFFF9, 32'd2, 1'b1, e, l);
    chk("model_m7_2", e, 64'hFFFFFFFF_FFFFFFFD);
    model(32'h80000000, 32'hFFFFFFFF, 1'b1, e, l);
    chk("model_min_m1", e, 64'h00000000_80000000);
    model(32'd3, 32'hFFFFFFF6, 1'b1, e, l);
    chk("model_3_m10", e, 64'h00000003_00000000);

    run_div(32'd100, 32'd7, 1'b0, 1, res, lat);
    chk("divu_100_7_res", res, 64'h00000002_0000000E);
    chk("divu_100_7_lat", 64'(lat), 64'd34);
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 0, res, lat);
    chk("div_m7_2_res", res, 64'hFFFFFFFF_FFFFFFFD);
    chk("div_m7_2_lat", 64'(lat), 64'd34);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, res, lat);
    chk("div_min_m1_res", res, 64'h00000000_80000000);
    run_div(32'd5, 32'd0, 1'b0, 2, res, lat);
    chk("divu_5_0_res", res, 64'd0);
    chk("divu_5_0_lat", 64'(lat), 64'd3);
    run_div(32'd3, 32'hFFFFFFF6, 1'b1, 0, res, lat);
    chk("div_3_m10_res", res, 64'h00000003_00000000);
    chk("div_3_m10_lat", 64'(lat), 64'(FAST_LAT));

    // annul in cycle 10 of DIVU 1000/3, new DIVU 9/4 in cycle 12
    start_raw(32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 bus.annul_i = 1'b1;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    chk("annul_state", 64'(dbg_state), 64'(DIV_FREE));
    run_div(32'd9, 32'd4, 1'b0, 0, res, lat);
    chk("after_annul_res", res, 64'h00000001_00000002);
    chk("after_annul_lat", 64'(lat), 64'd34);

    // annul with start held: start in the following cycle is accepted
    start_raw(32'd50, 32'd6);
    repeat (4) @(posedge clk);
    #1 bus.annul_i = 1'b1;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    run_div(32'd50, 32'd6, 1'b0, 0, res, lat);
    chk("restart_res", res, 64'h00000002_00000008);

    // synchronous reset in cycle 20 of an operation
    start_raw(32'd1000, 32'd3);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_state", 64'(dbg_state), 64'(DIV_FREE));
    chk("midrst_ready", 64'(bus.ready_o), 64'd0);
    chk("midrst_result", bus.result_o, 64'd0);

    // randomized divides
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: a = W'($urandom_range(0, 20));
        2: b = W'($urandom_range(1, 15));
        default: ;
      endcase
      run_div(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2), res, lat);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for the EX stage; executes DIV and DIVU.
- It is the producing end of the divide handshake that the hazard logic consumes: it drives ready_o, and the pipeline holds E while a divide is in E and ready_o=0.
- Result is {remainder, quotient}, written to HI/LO.
- Exception flush aborts the operation via annul_i.

Parameters:
- WIDTH, 32, operand width. Quotient and remainder are each WIDTH bits.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  divide request; held high by the pipeline until ready_o is seen.
- signed_i  in  1  1 = DIV (signed), 0 = DIVU.
- opa_i  in  WIDTH  dividend (rs).
- opb_i  in  WIDTH  divisor (rt).
- annul_i  in  1  abort current operation (exception flush).
- ready_o  out  1  result valid.
- result_o  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}.

Behaviour:
- Reset (rst=1 at an edge): state=FREE, ready_o=0, result_o=0, counter=0. Applies mid-operation too; the operation is discarded.
- States: FREE, BYZERO, ON, END. ready_o=1 only in END; it is registered.
- FREE:
  - start_i=1 and annul_i=0: latch operands and signed_i. Inputs are ignored from then until the next acceptance.
  - If opb_i=0, go to BYZERO. Otherwise go to ON with counter=0.
- Signed mode:
  - Operands are converted to magnitudes before iterating.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Negation is two's complement modulo 2^WIDTH, so 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- ON:
  - One restoring step per cycle: shift {rem, dividend} left, trial subtract the divisor magnitude, set the quotient bit if the result is non-negative.
  - Counter increments each step. After WIDTH steps, apply sign fix, load result_o, go to END.
  - Latency: start accepted in cycle 1, ready_o=1 in cycle WIDTH+2 (cycle 34 for WIDTH=32).
- BYZERO: result_o=0, go to END. ready_o=1 in cycle 3.
- END:
  - ready_o=1 and result_o stable while start_i=1.
  - When start_i=0: go to FREE, ready_o=0, result_o cleared to 0.
  - Back-to-back divides need at least one start_i=0 cycle between them; the pipeline guarantees this by advancing the instruction.
- annul_i=1 in any state:
  - Next state is FREE, ready_o=0, result_o=0.
  - annul_i has priority over start_i in the same cycle.
  - A start_i in the cycle after annul_i is accepted normally.

Optional Feature:
- Macro: DIV_FASTPATH_EN.
- Defined: in FREE, if opb_i≠0 and |opa_i| < |opb_i|:
  - Skip ON and go straight to END.
  - Quotient = 0, remainder = opa_i unchanged (sign preserved).
  - ready_o=1 in cycle 2.
- Undefined: all non-zero divisors take the full WIDTH+2 cycles.
- Results are identical either way; only latency differs.

Decomposition:
- Shared package / defines file holds:
  - state encodings DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END;
  - WIDTH default;
  - existing DIV_CONTROL/DIVU_CONTROL codes used by the decode that drives start_i and signed_i.
- One combinational sub-module, div_step: takes partial remainder, dividend MSB and divisor magnitude, and returns the next remainder and quotient bit.
- Sign conversion and the FSM stay in div_unit.

Test Plan:
- DIVU 100/7: start held → ready_o=1 exactly in cycle 34, result_o=64'h00000002_0000000E. Drop start_i → ready_o=0 next cycle, result_o=0.
- DIV -7/2 (0xFFFFFFF9 / 0x00000002) → result_o=64'hFFFFFFFF_FFFFFFFD, ready_o in cycle 34.
- DIV 0x80000000 / 0xFFFFFFFF → result_o=64'h00000000_80000000, no hang.
- DIVU 5/0 → ready_o=1 in cycle 3, result_o=0.
- Abort during ON:
  - Annul: start DIVU 1000/3, assert annul_i in cycle 10 → ready_o stays 0, state FREE. A new start in cycle 12 (DIVU 9/4) gives result_o=64'h00000001_00000002 in cycle 45.
  - Reset: rst in cycle 20 of an operation → ready_o=0, result_o=0, state FREE.
- With DIV_FASTPATH_EN, DIV 3/-10 → ready_o in cycle 2, result_o=64'h00000003_00000000. Without the macro, the same result arrives in cycle 34.
